// File: rtl/regfile_sb.sv
// regfile_sb: register file with pending-write busy bits and a post-reset init sweep.
// Define REGFILE_BYPASS_EN to forward the writeback value and busy clear to same-cycle reads.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    input  logic [ADDR_W-1:0] src1,
    input  logic [ADDR_W-1:0] src2,
    output logic [DATA_W-1:0] reg1,
    output logic [DATA_W-1:0] reg2,
    output logic              busy1,
    output logic              busy2,
    input  logic              Write_EN,
    input  logic [ADDR_W-1:0] dest,
    input  logic [DATA_W-1:0] Write_val,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_dest
);
    localparam int DEPTH = 2 ** ADDR_W;
    typedef enum logic {INIT, RUN} state_t;
    state_t            state, state_n;
    logic [ADDR_W:0]   idx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy, busy_n;
    logic              wr, iss, mem_we, m1, m2;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_d;
    always_comb begin
        ready    = state == RUN;
        wr       = ready && Write_EN && dest != '0;
        iss      = ready && issue_en && issue_dest != '0;
        state_n  = (state == INIT && idx == (ADDR_W+1)'(DEPTH - 1)) ? RUN : state;
        mem_we   = state == INIT || wr;
        mem_addr = state == INIT ? idx[ADDR_W-1:0] : dest;
        mem_d    = state == INIT ? DATA_W'(idx) : Write_val;
        busy_n   = busy;
        if (wr) busy_n[dest] = 1'b0;
        // a newer producer outranks the retiring one
        if (iss) busy_n[issue_dest] = 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            idx   <= '0;
            busy  <= '0;
        end else begin
            state <= state_n;
            idx   <= state == INIT ? idx + 1'b1 : idx;
            busy  <= busy_n;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst && mem_we) mem[mem_addr] <= mem_d;
    end
    always_comb begin
`ifdef REGFILE_BYPASS_EN
        m1 = wr && dest == src1;
        m2 = wr && dest == src2;
`else
        m1 = 1'b0;
        m2 = 1'b0;
`endif
        reg1  = (!ready || src1 == '0) ? '0 : m1 ? Write_val : mem[src1];
        reg2  = (!ready || src2 == '0) ? '0 : m2 ? Write_val : mem[src2];
        busy1 = ready && busy[src1] && !m1;
        busy2 = ready && busy[src2] && !m2;
    end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with a pending-write scoreboard and a self-initialising reset sweep. It serves as the decode-stage operand source for the MIPS pipeline. It provides two combinational read ports, one synchronous write port, and per-register busy bits that the hazard unit uses to stall on outstanding producers. Register 0 is hardwired to zero and is never busy.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, index width; DEPTH = 2**ADDR_W entries
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ready  out  1  high once the init sweep completes
- src1  in  ADDR_W  read port 1 index
- src2  in  ADDR_W  read port 2 index
- reg1  out  DATA_W  read port 1 data
- reg2  out  DATA_W  read port 2 data
- busy1  out  1  entry src1 has a pending write
- busy2  out  1  entry src2 has a pending write
- Write_EN  in  1  write strobe (writeback stage)
- dest  in  ADDR_W  write index
- Write_val  in  DATA_W  write data
- issue_en  in  1  mark issue_dest pending (decode stage)
- issue_dest  in  ADDR_W  index of the new producer

## Operation
- FSM states:
  - INIT: sweep counter idx (ADDR_W+1 bits). Each cycle writes entry[idx] = idx, zero-extended or truncated to DATA_W. Entry 0 is written as 0.
  - RUN: normal operation.
- rst=1 at an edge: state←INIT, idx←0, all busy bits←0. Reset may arrive at any time, including mid-sweep or mid-RUN; it restarts the sweep and discards any concurrent write or issue.
- INIT (rst=0): write entry[idx], then idx←idx+1. When idx=DEPTH−1 is written, state←RUN.
- ready = (state==RUN). While ready=0:
  - reg1, reg2, busy1 and busy2 read 0.
  - Write_EN and issue_en are ignored.
- Write in RUN: if Write_EN and dest≠0, entry[dest]←Write_val and busy[dest]←0 at the edge. A write with dest=0 is dropped.
- Issue in RUN: if issue_en and issue_dest≠0, busy[issue_dest]←1 at the edge.
- Simultaneous clear and set on the same index: set wins (busy stays 1, because a newer producer is outstanding). Data is still written.
- Reads are combinational:
  - regN = entry[srcN]; srcN=0 always returns 0.
  - busyN = busy[srcN]; busy[0] is constant 0.
- Both ports may read the same index. A write to index k does not affect a read of index j≠k.

## Timing
- Read latency: 0 cycles (combinational from the array and busy vector).
- Write latency: data is visible on reads in the cycle after the write edge, unless bypass is enabled (see Configuration).
- Busy set: visible the cycle after the issue edge. Busy clear: visible the cycle after the write edge, or same-cycle with bypass.
- ready rises after the DEPTH-th rising edge following rst deassertion; DEPTH=32 gives 32 cycles. ready falls at the first edge where rst=1.
- Reset values:
  - ready=0.
  - reg1, reg2, busy1, busy2 = 0.
  - busy vector all 0.
  - Array contents are undefined until the sweep writes each entry.

## Configuration
- REGFILE_BYPASS_EN defined: write-to-read forwarding is enabled.
  - When ready, Write_EN=1, dest≠0 and dest==srcN: regN=Write_val combinationally in the same cycle.
  - busyN = busy[srcN] & ~match, so the pending write resolves the same cycle.
  - Does not apply to src=0 or while ready=0.
- REGFILE_BYPASS_EN undefined: there is no forwarding. A read of the index being written returns the old value and the old busy bit until the next cycle.

## Test plan
- Reset sweep: rst high for 2 cycles, then low → ready=0 for 32 edges, then 1; reading src1=7 gives reg1=7; src2=0 gives 0.
- Write/read with bypass disabled: Write_EN=1, dest=5, Write_val=32'hDEADBEEF → reg1 (src1=5) shows old value 5 in the same cycle and DEADBEEF the next cycle. Write to dest=0 with value 32'h1234 → reg read of 0 stays 0.
- Scoreboard: issue_en with issue_dest=9 → busy1 (src1=9) = 1 the next cycle. Write dest=9 → busy1=0 the cycle after. Simultaneous issue and write to 9 → busy stays 1 and entry holds the written value.
- Bypass (REGFILE_BYPASS_EN): busy[3]=1, then Write_EN dest=3 Write_val=32'hA5A5A5A5 with src1=src2=3 → reg1=reg2=A5A5A5A5 and busy1=busy2=0 in the same cycle.
- Reset mid-operation: in RUN, write entry 4 = 32'hFF and set busy[6], then pulse rst → busy all 0, ready=0; after the 32-cycle sweep, entry 4 reads 4 and busy2 (src2=6) reads 0. Writes issued while ready=0 do not alter any entry.
